// File: rtl/cpu_sequencer_if.sv
// Bus between the CPU sequencer and its surroundings: run/step control,
// instruction memory port, decoder feedback and status outputs.
interface cpu_sequencer_if #(
   parameter int PC_W    = 4,
   parameter int INSTR_W = 8,
   parameter int CNT_W   = 8
);
   logic               run;
   logic               step;
   logic [INSTR_W-1:0] mem_rdata;
   logic               halt_dec;
   logic [PC_W-1:0]    mem_addr;
   logic               mem_re;
   logic [INSTR_W-1:0] ir;
   logic               rf_we;
   logic [PC_W-1:0]    pc;
   logic               halted;
   logic               busy;
   logic [CNT_W-1:0]   instr_count;
   logic [2:0]         state;

   modport master (
      input  run, step, mem_rdata, halt_dec,
      output mem_addr, mem_re, ir, rf_we, pc, halted, busy, instr_count, state
   );

   modport slave (
      output run, step, mem_rdata, halt_dec,
      input  mem_addr, mem_re, ir, rf_we, pc, halted, busy, instr_count, state
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Four-phase FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 8-bit CPU,
// with run, single-step and terminal halt control.
module cpu_sequencer #(
   parameter int PC_W    = 4,
   parameter int INSTR_W = 8,
   parameter int CNT_W   = 8
) (
   input logic             clk,
   input logic             reset,
   cpu_sequencer_if.master bus
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] DECODE    = 3'd2;
   localparam logic [2:0] EXECUTE   = 3'd3;
   localparam logic [2:0] WRITEBACK = 3'd4;
   localparam logic [2:0] HALTED    = 3'd5;

   logic [2:0]         state_q;
   logic [2:0]         state_nxt;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               single_q;
   logic               keep_running;

   // A single-stepped instruction never chains into the next one.
   assign keep_running = bus.run && !single_q;

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state_q;
      case (state_q)
         IDLE:      if (bus.run || bus.step) state_nxt = FETCH;
         FETCH:     state_nxt = DECODE;
         DECODE:    state_nxt = EXECUTE;
         EXECUTE:   state_nxt = bus.halt_dec ? HALTED : WRITEBACK;
         WRITEBACK: state_nxt = keep_running ? FETCH : IDLE;
         HALTED:    state_nxt = HALTED;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         cnt_q    <= '0;
         single_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, like real flops.
         state_q <= state_nxt;
         if (state_q == IDLE && !bus.run && bus.step)
            single_q <= 1'b1;
         if (state_q == DECODE)
            ir_q <= bus.mem_rdata;
         if (state_q == WRITEBACK) begin
            pc_q  <= pc_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
            if (!keep_running)
               single_q <= 1'b0;
         end
      end
   end

   // All outputs are registers or decodes of the registered state.
   assign bus.mem_addr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.ir          = ir_q;
   assign bus.instr_count = cnt_q;
   assign bus.state       = state_q;
   assign bus.mem_re      = (state_q == FETCH);
   assign bus.rf_we       = (state_q == WRITEBACK);
   assign bus.halted      = (state_q == HALTED);
   assign bus.busy        = (state_q == FETCH) || (state_q == DECODE) ||
                            (state_q == EXECUTE) || (state_q == WRITEBACK);
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level reference model compared every
// cycle, plus directed timing, wrap, halt, single-step and reset scenarios.
module tb_cpu_sequencer;
   localparam int PC_W    = 4;
   localparam int INSTR_W = 8;
   localparam int CNT_W   = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cpu_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

   cpu_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Instruction memory (synchronous read) and decoder: 0xF? is HALT.
   logic [7:0] mem [16];
   always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
   assign bus.halt_dec = (bus.ir[7:4] == 4'hF);

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks which cycle of the current instruction we are in
   // (0 = not executing, 1..4 = cycle within the instruction).
   int m_cyc, m_pc, m_cnt, m_ir;
   bit m_halted, m_single;

   function automatic bit is_halt(input int word);
      return word >= 8'hF0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cyc <= 0; m_pc <= 0; m_cnt <= 0; m_ir <= 0;
         m_halted <= 1'b0; m_single <= 1'b0;
      end else if (!m_halted) begin
         if (m_cyc == 0) begin
            if (bus.run || bus.step) m_cyc <= 1;
            if (!bus.run && bus.step) m_single <= 1'b1;
         end else if (m_cyc == 2) begin
            m_ir  <= int'(mem[m_pc]);
            m_cyc <= 3;
         end else if (m_cyc == 3) begin
            if (is_halt(m_ir)) begin
               m_halted <= 1'b1;
               m_cyc    <= 0;
            end else m_cyc <= 4;
         end else if (m_cyc == 4) begin
            m_pc  <= (m_pc + 1) % 16;
            m_cnt <= (m_cnt + 1) % 256;
            if (bus.run && !m_single) m_cyc <= 1;
            else begin
               m_cyc    <= 0;
               m_single <= 1'b0;
            end
         end else m_cyc <= m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("state",    32'(bus.state),       m_halted ? 5 : m_cyc);
         check("pc",       32'(bus.pc),          m_pc);
         check("mem_addr", 32'(bus.mem_addr),    m_pc);
         check("ir",       32'(bus.ir),          m_ir);
         check("count",    32'(bus.instr_count), m_cnt);
         check("mem_re",   32'(bus.mem_re),      32'(m_cyc == 1));
         check("rf_we",    32'(bus.rf_we),       32'(m_cyc == 4));
         check("halted",   32'(bus.halted),      32'(m_halted));
         check("busy",     32'(bus.busy),        32'(m_cyc != 0));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_en = 1'b1;
      check("rst_state", 32'(bus.state), 0);
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_ir", 32'(bus.ir), 0);
      check("rst_count", 32'(bus.instr_count), 0);
      check("rst_outs", {28'd0, bus.mem_re, bus.rf_we, bus.halted, bus.busy}, 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_mem(input bit with_halts);
      for (int i = 0; i < 16; i++) begin
         if (with_halts && $urandom_range(0, 11) == 0) mem[i] = 8'hF0 | 8'($urandom_range(0, 15));
         else mem[i] = 8'($urandom_range(1, 8'hEF));
      end
   endtask

   int pulses, wb_seen;
   bit found;

   initial begin
      reset = 1'b0;
      bus.run = 1'b0;
      bus.step = 1'b0;
      fill_mem(1'b0);
      mem[0] = 8'h21;

      // Reset and idle with run low.
      assert_reset();
      cyc(2);
      release_reset();
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("idle_state", 32'(bus.state), 0);
         check("idle_pc", 32'(bus.pc), 0);
         check("idle_we_re", {30'd0, bus.mem_re, bus.rf_we}, 0);
         check("idle_count", 32'(bus.instr_count), 0);
      end

      // Run timing, then 16 instructions to wrap pc.
      bus.run = 1'b1;
      wb_seen = 0;
      for (int c = 1; c <= 65; c++) begin
         cyc(1);
         if (c == 1) begin
            check("t1_mem_re", 32'(bus.mem_re), 1);
            check("t1_mem_addr", 32'(bus.mem_addr), 0);
         end
         if (c == 3) check("t3_ir", 32'(bus.ir), 32'h21);
         if (c == 5) begin
            check("t5_pc", 32'(bus.pc), 1);
            check("t5_count", 32'(bus.instr_count), 1);
            check("t5_fetch", 32'(bus.state), 1);
         end
         check("rf_we_slot", 32'(bus.rf_we), 32'(c % 4 == 0));
         if (bus.rf_we) begin
            check("wb_pc", 32'(bus.pc), 32'(wb_seen % 16));
            wb_seen++;
         end
      end
      check("wrap_pc", 32'(bus.pc), 0);
      check("wrap_count", 32'(bus.instr_count), 16);
      bus.run = 1'b0;   // dropped in FETCH: instruction still completes
      cyc(4);
      check("drop_state", 32'(bus.state), 0);
      check("drop_busy", 32'(bus.busy), 0);
      check("drop_pc", 32'(bus.pc), 1);
      check("drop_count", 32'(bus.instr_count), 17);

      // Single step with an ignored second pulse in FETCH.
      assert_reset();
      release_reset();
      bus.step = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc(1);
         bus.step = (c == 1);
         pulses += int'(bus.rf_we);
         if (c == 5) begin
            check("step_idle", 32'(bus.state), 0);
            check("step_busy", 32'(bus.busy), 0);
         end
      end
      check("step_pulses", pulses, 1);
      check("step_pc", 32'(bus.pc), 1);
      check("step_count", 32'(bus.instr_count), 1);

      // Halt at address 2.
      assert_reset();
      mem[2] = 8'hF3;
      release_reset();
      bus.run = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc(1);
         pulses += int'(bus.rf_we);
         if (c == 11) check("halt_c11", {31'd0, bus.halted}, 0);
      end
      check("halt_c12", {31'd0, bus.halted}, 1);
      check("halt_pulses", pulses, 2);
      check("halt_pc", 32'(bus.pc), 2);
      check("halt_count", 32'(bus.instr_count), 2);
      for (int c = 0; c < 20; c++) begin
         bus.run = 1'($urandom_range(0, 1));
         bus.step = 1'($urandom_range(0, 1));
         cyc(1);
         check("halt_no_we", 32'(bus.rf_we), 0);
         check("halt_stay", 32'(bus.state), 5);
      end
      bus.run = 1'b0;
      bus.step = 1'b0;

      // Reset during EXECUTE of the third instruction.
      assert_reset();
      mem[2] = 8'h5A;
      release_reset();
      bus.run = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         cyc(1);
         found = (bus.state == 3'd3 && bus.pc == 4'd2);
      end
      check("midop_reached", 32'(found), 1);
      #2 reset = 1'b1;
      #1;
      check("midop_pc", 32'(bus.pc), 0);
      check("midop_ir", 32'(bus.ir), 0);
      check("midop_count", 32'(bus.instr_count), 0);
      for (int c = 0; c < 3; c++) begin
         cyc(1);
         check("midop_rst_we", 32'(bus.rf_we), 0);
      end
      bus.run = 1'b0;
      release_reset();
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         check("midop_after_we", 32'(bus.rf_we), 0);
      end

      // Randomized run/step/reset traffic against the model.
      for (int r = 0; r < 6; r++) begin
         assert_reset();
         fill_mem(1'b1);
         release_reset();
         for (int c = 0; c < 300; c++) begin
            cyc(1);
            if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
            bus.step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
               #2 reset = 1'b1;
               cyc(1);
               #2 reset = 1'b0;
            end
         end
      end

      bus.run = 1'b0;
      bus.step = 1'b0;
      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit CPU datapath. It replaces the free-running per-clock PC increment and the permanently enabled register-file write with a four-phase FETCH/DECODE/EXECUTE/WRITEBACK state machine. It drives the instruction memory address and read enable, holds the instruction register, gates the register-file write, and provides run/single-step/halt control. The instruction decoder and ALU stay combinational and sit between `ir` and the register file.

## Interface

- `PC_W`, 4, program counter / instruction memory address width
- `INSTR_W`, 8, instruction width
- `CNT_W`, 8, retired-instruction counter width

- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-high; clock `clk`
- `run`  input  1  level; while high, execute instructions back-to-back
- `step`  input  1  one-cycle pulse; in IDLE with `run`=0, execute exactly one instruction
- `mem_rdata`  input  INSTR_W  instruction memory read data; synchronous read, valid the cycle after `mem_re`
- `halt_dec`  input  1  halt flag from the decoder, driven combinationally from `ir`
- `mem_addr`  output  PC_W  instruction memory address (= `pc`)
- `mem_re`  output  1  instruction memory read enable
- `ir`  output  INSTR_W  instruction register, feeds the decoder
- `rf_we`  output  1  register-file write enable
- `pc`  output  PC_W  program counter
- `halted`  output  1  high in HALTED state
- `busy`  output  1  high in FETCH, DECODE, EXECUTE or WRITEBACK
- `instr_count`  output  CNT_W  number of retired (written-back) instructions
- `state`  output  3  encoded state, for debug

## Operation

- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5; codes 6 and 7 go to IDLE on the next edge.
- **IDLE:**
  - `run`=1 → FETCH.
  - else `step`=1 → FETCH, and the `single` flag is set.
  - else stay in IDLE.
- **FETCH:** `mem_re`=1, `mem_addr`=`pc`; always → DECODE.
- **DECODE:** `mem_rdata` is valid; `ir` <= `mem_rdata` at the exit edge; → EXECUTE.
- **EXECUTE:**
  - `halt_dec` is evaluated from the new `ir`.
  - `halt_dec`=1 → HALTED. `pc` is not incremented, `rf_we` is never asserted and `instr_count` is unchanged.
  - `halt_dec`=0 → WRITEBACK.
- **WRITEBACK:**
  - `rf_we`=1 for exactly this cycle.
  - At the exit edge: `pc` <= `pc`+1 modulo 2^PC_W, so 15 wraps to 0; `instr_count` <= `instr_count`+1 modulo 2^CNT_W, wrapping.
  - Exit: if `run`=1 and `single`=0 → FETCH. Otherwise → IDLE, and `single` is cleared.
- **HALTED:** terminal; only `reset` exits. `run` and `step` are ignored.
- `step` pulses while not in IDLE are ignored, not queued.
- `run`=1 together with `step` in IDLE: `run` wins and `single` stays 0.
- Dropping `run` mid-instruction: the current instruction completes through WRITEBACK, then → IDLE.
- `mem_re` and `rf_we` are 0 in every state not listed above.
- `ir` changes only at the DECODE exit edge.
- `pc` changes only at the WRITEBACK exit edge or on reset.

## Timing

- Reset values, asynchronous and immediate:
  - state=IDLE, `pc`=0, `ir`=0, `instr_count`=0, `single`=0.
  - `mem_re`=0, `rf_we`=0, `halted`=0, `busy`=0.
- All outputs are registered or decoded from state only; there are no combinational input→output paths. Exception: `mem_addr` equals `pc`, which is a register.
- Latency: 4 cycles per instruction.
  - `run` sampled high in IDLE at edge E0 → FETCH during cycle 1.
  - `rf_we` is high in cycle 4.
  - The new `pc` is visible from cycle 5.
- Sustained `run`: FETCH follows WRITEBACK with no bubble, giving 1 instruction per 4 clocks.
- Single step: from the `step` edge to return to IDLE takes 5 edges; IDLE is entered with `busy`=0.
- A HALT instruction reaches HALTED 3 cycles after entering FETCH; `halted` rises the cycle after EXECUTE.
- Reset asserted mid-instruction (any state): every register returns to its reset value immediately. No `rf_we` pulse is emitted after `reset` rises.

## Test plan

- Reset/idle: assert `reset`, release with `run`=0 for 10 cycles → state=0, `pc`=0, `mem_re`=0, `rf_we`=0, `instr_count`=0 throughout.
- Run timing: memory word 0=0x21, `run`=1 from cycle 0 →
  - `mem_re`=1, `mem_addr`=0 in cycle 1.
  - `ir`=0x21 in cycle 3.
  - `rf_we`=1 only in cycle 4.
  - `pc`=1 and `instr_count`=1 in cycle 5; next FETCH is in cycle 5.
- PC wrap: 16 non-halt instructions under `run` → `pc` sequence 0..15 then 0, `instr_count`=16 after 64 cycles.
- Halt: halt instruction at address 2, `run`=1 →
  - 2 write-backs occur.
  - `halted`=1 with `pc`=2 and `instr_count`=2.
  - `rf_we` stays 0 for 20 further cycles.
  - Toggling `run`/`step` has no effect.
- Single step: `run`=0, one `step` pulse → exactly one `rf_we` pulse, `pc` 0→1, back in IDLE. A second `step` pulse during FETCH is ignored (`pc` stays 1 after the instruction completes).
- Reset mid-op: assert `reset` in the EXECUTE cycle of the 3rd instruction → `pc`=0, `ir`=0, `instr_count`=0 immediately, and no `rf_we` pulse follows.
